// File: rtl/reg_dump_tx_if.sv
// reg_dump_tx_if: bundles the dump engine's control, register-file read port
// and serial output.
//   start    - dump request (to engine)
//   readReg  - register-file read index (from engine)
//   readData - register-file read data, combinational from readReg (to engine)
//   tx       - UART 8N1 serial line, idles high (from engine)
//   busy     - dump in progress (from engine)
//   done     - one-cycle completion pulse (from engine)
// master: the dump engine. slave: the register file / requester side.
interface reg_dump_tx_if;
  logic       start;
  logic [1:0] readReg;
  logic [7:0] readData;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (input start, readData, output readReg, tx, busy, done);
  modport slave  (output start, readData, input readReg, tx, busy, done);
endinterface

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks register indices 0..NUM_REGS-1 through the register-file
// read port and sends each captured byte as a UART 8N1 frame (LSB first).
// Each register takes 1 LOAD cycle + 10 bit times; DONE pulses once at the end.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous, active-high; abandons any frame, tx back to idle
//   bus   - reg_dump_tx_if.master (start, readReg, readData, tx, busy, done)
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 4
) (
  input logic          clk,
  input logic          reset,
  reg_dump_tx_if.master bus
);

  localparam int         BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;

  state_t        state;
  logic [BW-1:0] baudCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;

  wire baudEnd = (baudCnt == BAUD_LAST);

  // readReg doubles as the register index: it must hold the index through
  // LOAD and keep the last value after the dump anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      baudCnt     <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      bus.readReg <= '0;
      bus.tx      <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.tx <= 1'b1;
          if (bus.start) begin
            bus.readReg <= '0;
            bus.busy    <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          // readData is valid this cycle for the index on readReg.
          shiftReg <= bus.readData;
          baudCnt  <= '0;
          bus.tx   <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baudEnd) begin
            baudCnt  <= '0;
            bitCnt   <= '0;
            bus.tx   <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            state    <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              bus.tx <= 1'b1;
              state  <= STOP;
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              bus.tx   <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (bus.readReg == LAST_IDX) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.readReg <= bus.readReg + 1'b1;
              state       <= LOAD;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DONE: begin
          // start is not sampled here; a held start is picked up in IDLE.
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
